// File: rtl/data_mem_lsu_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the data-memory load/store unit: FSM state codes,
// load/store select encodings coming from the main decoder, and the
// store-data lane formatter.
package data_mem_lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_t;

  localparam logic [3:0] LD_LW  = 4'b0001;
  localparam logic [3:0] LD_LB  = 4'b0101;
  localparam logic [3:0] LD_LBU = 4'b0110;
  localparam logic [3:0] LD_LH  = 4'b0111;
  localparam logic [3:0] LD_LHU = 4'b1000;
  localparam logic [3:0] LD_LWL = 4'b1001;
  localparam logic [3:0] LD_LWR = 4'b1010;

  localparam logic [2:0] SS_SW  = 3'b000;
  localparam logic [2:0] SS_SB  = 3'b001;
  localparam logic [2:0] SS_SH  = 3'b010;
  localparam logic [2:0] SS_SWL = 3'b011;
  localparam logic [2:0] SS_SWR = 3'b100;

  // Load selects that actually touch memory; anything else flagged
  // load-class (e.g. lui) completes without a bus access.
  function automatic logic load_sel_known(input logic [3:0] sel);
    case (sel)
      LD_LW, LD_LB, LD_LBU, LD_LH, LD_LHU, LD_LWL, LD_LWR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Places rt into the byte lanes selected by the store type and address.
  function automatic logic [31:0] store_format(input logic [2:0]  sel,
                                               input logic [1:0]  a,
                                               input logic [31:0] rt);
    case (sel)
      SS_SW:   return rt;
      SS_SB:   return {4{rt[7:0]}};
      SS_SH:   return {2{rt[15:0]}};
      SS_SWL:  return rt >> {2'd3 - a, 3'b000};
      SS_SWR:  return rt << {a, 3'b000};
      default: return rt;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_lsu_load_align.sv
`timescale 1ns/1ps
// Combinational load formatter: selects, extends and merges bus read data
// with rt for partial and unaligned loads.
module data_mem_lsu_load_align
  import data_mem_lsu_pkg::*;
(
  input  logic [3:0]  load_sel,
  input  logic [1:0]  a,
  input  logic [31:0] rdata,
  input  logic [31:0] rt,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword out of the read word.
  always_comb begin
    byte_sel = rdata[7:0];
    case (a)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = a[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extend or merge according to the load type.
  always_comb begin
    load_data = '0;
    case (load_sel)
      LD_LW:  load_data = rdata;
      LD_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU: load_data = {24'd0, byte_sel};
      LD_LH:  load_data = {{16{half_sel[15]}}, half_sel};
      LD_LHU: load_data = {16'd0, half_sel};
      LD_LWL: begin
        case (a)
          2'd0: load_data = {rdata[7:0],  rt[23:0]};
          2'd1: load_data = {rdata[15:0], rt[15:0]};
          2'd2: load_data = {rdata[23:0], rt[7:0]};
          default: load_data = rdata;
        endcase
      end
      LD_LWR: begin
        case (a)
          2'd0: load_data = rdata;
          2'd1: load_data = {rt[31:24], rdata[31:8]};
          2'd2: load_data = {rt[31:16], rdata[31:16]};
          default: load_data = {rt[31:8], rdata[31:24]};
        endcase
      end
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
`timescale 1ns/1ps
// Load/store unit: accepts one memory op at a time, runs a single
// req/addr_ok/data_ok bus transaction, and returns the formatted result.
//
//   state  | meaning
//   IDLE   | op_ready high, waiting for op_valid
//   REQ    | data_req high, waiting for data_addr_ok
//   WAIT   | address accepted, waiting for data_data_ok
//   DONE   | resp_valid pulse, back to IDLE next cycle
module data_mem_lsu
  import data_mem_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [3:0]  wen,
  input  logic [3:0]  load_sel,
  input  logic [2:0]  store_sel,
  input  logic [31:0] rt_value,
  output logic        data_req,
  output logic        data_wr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err
);

  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Down-counter is loaded with TIMEOUT-1 so terminal count lands after
  // exactly TIMEOUT cycles spent in REQ+WAIT.
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t      state;
  logic [WD_W-1:0] wd_cnt;
  logic [3:0]      cap_load_sel;
  logic [1:0]      cap_a;
  logic [31:0]     cap_rt;
  logic [31:0]     align_data;
  logic            go_bus;
  logic            wd_tc;

  // A store wins over a load; stores with no strobes and unknown load
  // selects complete without touching the bus.
  assign go_bus = mem_write ? (wen != 4'b0000)
                            : (mem_read & load_sel_known(load_sel));
  assign wd_tc  = (TIMEOUT_CYCLES != 0) && (wd_cnt == '0);

  data_mem_lsu_load_align u_load_align (
    .load_sel  (cap_load_sel),
    .a         (cap_a),
    .rdata     (data_rdata),
    .rt        (cap_rt),
    .load_data (align_data)
  );

  // Sequencer, operand capture, bus outputs and watchdog.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      op_ready     <= 1'b1;
      data_req     <= 1'b0;
      data_wr      <= 1'b0;
      data_wstrb   <= 4'b0000;
      data_addr    <= '0;
      data_wdata   <= '0;
      resp_valid   <= 1'b0;
      resp_err     <= 1'b0;
      resp_data    <= '0;
      wd_cnt       <= '0;
      cap_load_sel <= 4'b0000;
      cap_a        <= 2'b00;
      cap_rt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          if (op_valid) begin
            op_ready     <= 1'b0;
            cap_load_sel <= load_sel;
            cap_a        <= addr[1:0];
            cap_rt       <= rt_value;
            data_wr      <= mem_write;
            data_wstrb   <= wen;
            data_addr    <= {addr[31:2], 2'b00};
            data_wdata   <= store_format(store_sel, addr[1:0], rt_value);
            resp_data    <= '0;
            if (go_bus) begin
              state    <= S_REQ;
              data_req <= 1'b1;
              wd_cnt   <= WD_LOAD;
            end else begin
              state      <= S_DONE;
              resp_valid <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (data_addr_ok) begin
            data_req <= 1'b0;
            if (data_data_ok) begin
              state      <= S_DONE;
              resp_valid <= 1'b1;
              resp_data  <= data_wr ? 32'd0 : align_data;
            end else begin
              state  <= S_WAIT;
              wd_cnt <= wd_cnt - 1'b1;
            end
          end else if (wd_tc) begin
            state      <= S_DONE;
            data_req   <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_data  <= '0;
          end else begin
            wd_cnt <= wd_cnt - 1'b1;
          end
        end
        S_WAIT: begin
          if (data_data_ok) begin
            state      <= S_DONE;
            resp_valid <= 1'b1;
            resp_data  <= data_wr ? 32'd0 : align_data;
          end else if (wd_tc) begin
            state      <= S_DONE;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_data  <= '0;
          end else begin
            wd_cnt <= wd_cnt - 1'b1;
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          op_ready   <= 1'b1;
        end
        default: begin
          state    <= S_IDLE;
          op_ready <= 1'b1;
          data_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
`timescale 1ns/1ps
// Bench for data_mem_lsu: directed ops with a byte-lane model of the load
// and store rules, a per-cycle compare process, and literal expectations.
module tb_data_mem_lsu;

  localparam int TO = 255;

  localparam logic [3:0] L_LW = 4'b0001, L_LB = 4'b0101, L_LBU = 4'b0110,
                         L_LH = 4'b0111, L_LHU = 4'b1000, L_LWL = 4'b1001,
                         L_LWR = 4'b1010, L_LUI = 4'b0000;
  localparam logic [2:0] W_SW = 3'b000, W_SB = 3'b001, W_SH = 3'b010,
                         W_SWL = 3'b011, W_SWR = 3'b100;

  logic        clk = 1'b0;
  logic        resetn;
  logic        op_valid, op_ready, mem_read, mem_write;
  logic [31:0] addr, rt_value;
  logic [3:0]  wen, load_sel;
  logic [2:0]  store_sel;
  logic        data_req, data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_data;

  data_mem_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_ready(op_ready),
    .mem_read(mem_read), .mem_write(mem_write), .addr(addr), .wen(wen),
    .load_sel(load_sel), .store_sel(store_sel), .rt_value(rt_value),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  // Expectations for the op in flight, written only by the driver.
  logic        e_store = 0, e_bus = 0, e_err = 0;
  logic [3:0]  e_lsel = 0, e_wen = 0;
  logic [2:0]  e_ssel = 0;
  logic [31:0] e_addr = 0, e_rt = 0, e_rd = 0;
  int          e_lat = -1;
  logic        lit_on = 0, litw_on = 0;
  logic [31:0] lit_resp = 0, lit_wdata = 0;
  int          drv_to = 0;

  // ---------------- reference model ----------------
  function automatic logic m_known(input logic [3:0] s);
    return (s == L_LW) || (s == L_LB) || (s == L_LBU) || (s == L_LH) ||
           (s == L_LHU) || (s == L_LWL) || (s == L_LWR);
  endfunction

  function automatic logic [31:0] m_store(input logic [2:0] s, input logic [31:0] ad,
                                          input logic [31:0] rt);
    int sh;
    sh = 8 * int'(ad[1:0]);
    case (s)
      W_SB:  return {4{rt[7:0]}};
      W_SH:  return {2{rt[15:0]}};
      W_SWL: return rt >> (24 - sh);
      W_SWR: return rt << sh;
      default: return rt;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] s, input logic [31:0] ad,
                                         input logic [31:0] rt, input logic [31:0] rd);
    int sh;
    logic [31:0] ones, b, h;
    ones = 32'hFFFF_FFFF;
    sh = 8 * int'(ad[1:0]);
    b = (rd >> sh) & 32'h0000_00FF;
    h = (rd >> (16 * int'(ad[1]))) & 32'h0000_FFFF;
    case (s)
      L_LW:  return rd;
      L_LB:  return b[7] ? (b | 32'hFFFF_FF00) : b;
      L_LBU: return b;
      L_LH:  return h[15] ? (h | 32'hFFFF_0000) : h;
      L_LHU: return h;
      L_LWL: return (rd << (24 - sh)) | (rt & (ones >> (sh + 8)));
      L_LWR: return (rd >> sh) | (rt & ~(ones >> sh));
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- compare process ----------------
  int   checks = 0, errors = 0;
  int   n = 0, acc_n = 0, to_seen = 0;
  logic busy = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Checks every cycle: reset values, op_ready vs. outstanding op, bus
  // fields while requesting, and the response against the model.
  always @(negedge clk) begin
    n++;
    if (drv_to != to_seen) begin
      errors++;
      $display("FAIL op_complete: no resp_valid within driver budget (t=%0t)", $time);
      to_seen = drv_to;
    end
    if (!resetn) begin
      busy = 0;
      chk("rst_op_ready", op_ready, 1);
      chk("rst_ctrl", {data_req, data_wr, resp_valid, resp_err, data_wstrb}, 0);
      chk("rst_addr", data_addr, 0);
      chk("rst_wdata", data_wdata, 0);
      chk("rst_resp_data", resp_data, 0);
    end else begin
      chk("op_ready", op_ready, !busy);
      if (data_req) begin
        chk("req_in_op", busy && e_bus, 1);
        chk("data_addr", data_addr, e_addr & 32'hFFFF_FFFC);
        chk("data_wr", data_wr, e_store);
        chk("data_wstrb", data_wstrb, e_wen);
        if (e_store) chk("data_wdata", data_wdata, m_store(e_ssel, e_addr, e_rt));
        if (litw_on) chk("lit_wdata", data_wdata, lit_wdata);
      end
      if (resp_valid) begin
        chk("resp_in_op", busy, 1);
        chk("resp_data", resp_data,
            (e_err || e_store || !e_bus) ? 32'd0 : m_load(e_lsel, e_addr, e_rt, e_rd));
        chk("resp_err", resp_err, e_err);
        chk("resp_req_low", data_req, 0);
        if (e_lat >= 0) chk("latency", n - acc_n, e_lat);
        if (lit_on) chk("lit_resp", resp_data, lit_resp);
        busy = 0;
      end
      if (op_valid && op_ready) begin
        busy  = 1;
        acc_n = n;
      end
    end
  end

  // ---------------- driver ----------------
  // ao: REQ cycle index at which addr_ok is given (<0: never).
  // gap: cycles after addr_ok until data_ok (0: same cycle, <0: never).
  task automatic run_op(input logic mr, input logic mw, input logic [31:0] ad,
                        input logic [3:0] wn, input logic [3:0] ls, input logic [2:0] ss,
                        input logic [31:0] rt, input logic [31:0] rd,
                        input int ao, input int gap,
                        input logic lon, input logic [31:0] lres,
                        input logic lwon, input logic [31:0] lwd);
    logic done;
    e_store = mw;
    e_bus   = mw ? (wn != 4'b0000) : (mr && m_known(ls));
    e_err   = e_bus && (ao < 0 || gap < 0);
    e_lsel = ls; e_wen = wn; e_ssel = ss; e_addr = ad; e_rt = rt; e_rd = rd;
    // Latency in cycles from the cycle op_valid is accepted to resp_valid.
    e_lat   = !e_bus ? 1 : (e_err ? TO + 1 : ao + gap + 2);
    lit_on = lon; lit_resp = lres; litw_on = lwon; lit_wdata = lwd;
    mem_read = mr; mem_write = mw; addr = ad; wen = wn; load_sel = ls;
    store_sel = ss; rt_value = rt;
    op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    addr = $urandom; rt_value = $urandom; wen = 4'($urandom);
    load_sel = 4'($urandom); store_sel = 3'($urandom);
    mem_read = 1'($urandom); mem_write = 1'($urandom);
    done = 1'b0;
    for (int c = 0; c < TO + 40; c++) begin
      if (resp_valid) begin
        done = 1'b1;
        break;
      end
      data_addr_ok = (ao >= 0) && (c == ao);
      data_data_ok = (ao >= 0) && (gap >= 0) && (c == ao + gap);
      data_rdata   = data_data_ok ? rd : $urandom;
      @(posedge clk); #1;
    end
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    if (!done) drv_to++;
    @(posedge clk); #1;
  endtask

  // Reset asserted mid-op (in REQ when ao<0, else in WAIT), then a stray
  // data_ok after release that must not produce a response.
  task automatic reset_mid(input logic [31:0] ad, input int ao);
    e_store = 0; e_bus = 1; e_err = 0; e_lsel = L_LW; e_wen = 0; e_ssel = W_SW;
    e_addr = ad; e_rt = 0; e_rd = 0; e_lat = -1; lit_on = 0; litw_on = 0;
    mem_read = 1; mem_write = 0; addr = ad; wen = 0; load_sel = L_LW; rt_value = 0;
    op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    if (ao >= 0) data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0;
    repeat (2) @(posedge clk);
    #2 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;
    data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; op_valid = 0; mem_read = 0; mem_write = 0; addr = 0; wen = 0;
    load_sel = 0; store_sel = 0; rt_value = 0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;

    //     mr mw addr          wen    lsel   ssel   rt            rd            ao gap lit resp        litw wdata
    run_op(0, 1, 32'h0000_1004, 4'hF, L_LW,  W_SW,  32'hA1B2_C3D4, 32'h0,        0, 0, 1, 32'h0,        1, 32'hA1B2_C3D4);
    run_op(1, 0, 32'h0000_2003, 4'h0, L_LB,  W_SW,  32'h0,         32'h80FF_7F01, 0, 0, 1, 32'hFFFF_FF80, 0, 32'h0);
    run_op(1, 0, 32'h0000_2003, 4'h0, L_LBU, W_SW,  32'h0,         32'h80FF_7F01, 1, 2, 1, 32'h0000_0080, 0, 32'h0);
    run_op(1, 0, 32'h0000_2002, 4'h0, L_LHU, W_SW,  32'h0,         32'h80FF_7F01, 0, 1, 1, 32'h0000_80FF, 0, 32'h0);
    run_op(1, 0, 32'h0000_4001, 4'h0, L_LWL, W_SW,  32'h1122_3344, 32'hAABB_CCDD, 0, 0, 1, 32'hCCDD_3344, 0, 32'h0);
    run_op(1, 0, 32'h0000_4002, 4'h0, L_LWR, W_SW,  32'h1122_3344, 32'hAABB_CCDD, 2, 0, 1, 32'h1122_AABB, 0, 32'h0);
    run_op(0, 1, 32'h0000_3001, 4'hE, L_LW,  W_SWR, 32'h1122_3344, 32'h0,        0, 0, 1, 32'h0,        1, 32'h2233_4400);
    run_op(0, 1, 32'h0000_3002, 4'h4, L_LW,  W_SB,  32'h0000_005A, 32'h0,        1, 0, 1, 32'h0,        1, 32'h5A5A_5A5A);
    run_op(1, 0, 32'h0000_8000, 4'h0, L_LUI, W_SW,  32'h0,         32'h0,        0, 0, 1, 32'h0,        0, 32'h0);
    run_op(1, 0, 32'h0000_5000, 4'h0, L_LW,  W_SW,  32'h0,         32'hFFFF_FFFF, -1, 0, 1, 32'h0,      0, 32'h0);
    run_op(1, 0, 32'h0000_7000, 4'h0, L_LH,  W_SW,  32'h0,         32'h0000_8001, 0, 0, 1, 32'hFFFF_8001, 0, 32'h0);
    run_op(1, 0, 32'h0000_7FF8, 4'h0, L_LW,  W_SW,  32'h0,         32'hDEAD_BEEF, 2, 3, 1, 32'hDEAD_BEEF, 0, 32'h0);
    run_op(0, 1, 32'h0000_3001, 4'h3, L_LW,  W_SWL, 32'h1122_3344, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0000_1122);
    run_op(0, 1, 32'h0000_3002, 4'hC, L_LW,  W_SH,  32'hABCD_1234, 32'h0,        0, 1, 0, 32'h0,        1, 32'h1234_1234);
    run_op(0, 1, 32'h0000_3000, 4'h0, L_LW,  W_SW,  32'h5555_AAAA, 32'h0,        0, 0, 1, 32'h0,        0, 32'h0);
    run_op(1, 0, 32'h0000_4003, 4'h0, L_LWL, W_SW,  32'h1122_3344, 32'hAABB_CCDD, 0, 0, 1, 32'hAABB_CCDD, 0, 32'h0);
    run_op(1, 0, 32'h0000_4000, 4'h0, L_LWR, W_SW,  32'h1122_3344, 32'hAABB_CCDD, 0, 0, 1, 32'hAABB_CCDD, 0, 32'h0);
    run_op(1, 1, 32'h0000_600C, 4'hF, L_LW,  W_SW,  32'h0BAD_F00D, 32'h7777_7777, 0, 0, 1, 32'h0,        1, 32'h0BAD_F00D);
    run_op(1, 0, 32'h0000_9000, 4'h0, L_LW,  W_SW,  32'h0,         32'h0,        0, -1, 1, 32'h0,       0, 32'h0);

    // Bus handshakes while idle must be ignored.
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hCAFE_BABE;
    repeat (2) @(posedge clk);
    #1 data_addr_ok = 1'b0; data_data_ok = 1'b0;
    @(posedge clk); #1;

    reset_mid(32'h0000_A000, 0);
    reset_mid(32'h0000_B000, -1);

    // Normal operation resumes after a mid-op reset.
    run_op(1, 0, 32'h0000_2001, 4'h0, L_LB,  W_SW,  32'h0,         32'h80FF_7F01, 0, 0, 1, 32'h0000_007F, 0, 32'h0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
